// File: rtl/dcache_mshr_queue.sv
// dcache_mshr_queue
//   Miss-status holding queue between the data cache and the memory controller.
//   Load misses and line writebacks are allocated in port order into a circular
//   queue, issued to memory strictly in order (one per cycle), and retired in
//   order when the head's memory tag comes back. Secondary load misses to a line
//   whose youngest pending entry is a load are merged instead of re-fetched.
//
// Ports
//   clock, reset                      clock; synchronous active-high reset
//   ld_miss_valid/addr -> ld_accept/ld_stall   load-miss request ports
//   wb_valid/addr/data -> wb_stall             writeback request ports
//   mem_command/addr/data                      request driven to memory
//   mem_response                               nonzero = driven request taken, with tag
//   mem_tag/mem_rdata                          returning transaction
//   refill_en/addr/data                        cache array refill on load retire
//   bcast_valid/addr/data                      wake-up broadcast on load retire
module dcache_mshr_queue #(
    parameter int XLEN     = 32,
    parameter int LD_PORTS = 2,
    parameter int ST_PORTS = 3,
    parameter int DEPTH    = 8,
    parameter int MTAG_W   = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [LD_PORTS-1:0]            ld_miss_valid,
    input  logic [LD_PORTS-1:0][XLEN-1:0]  ld_miss_addr,
    output logic [LD_PORTS-1:0]            ld_accept,
    output logic [LD_PORTS-1:0]            ld_stall,
    input  logic [ST_PORTS-1:0]            wb_valid,
    input  logic [ST_PORTS-1:0][XLEN-1:0]  wb_addr,
    input  logic [ST_PORTS-1:0][63:0]      wb_data,
    output logic [ST_PORTS-1:0]            wb_stall,
    output logic [1:0]                     mem_command,
    output logic [XLEN-1:0]                mem_addr,
    output logic [63:0]                    mem_data,
    input  logic [MTAG_W-1:0]              mem_response,
    input  logic [MTAG_W-1:0]              mem_tag,
    input  logic [63:0]                    mem_rdata,
    output logic                           refill_en,
    output logic [XLEN-1:0]                refill_addr,
    output logic [63:0]                    refill_data,
    output logic                           bcast_valid,
    output logic [XLEN-1:0]                bcast_addr,
    output logic [63:0]                    bcast_data
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LINE_W = XLEN - 3;
    localparam int NPORTS = LD_PORTS + ST_PORTS;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_t;

    typedef struct packed {
        logic              valid;
        bus_cmd_t          cmd;
        logic [LINE_W-1:0] line;
        logic [63:0]       data;
        logic              issued;
        logic [MTAG_W-1:0] mtag;
    } entry_t;

    entry_t            q [DEPTH];
    logic [PTR_W-1:0]  head_ptr, issue_ptr, tail_ptr;
    logic [CNT_W-1:0]  count;

    logic              issue_req, issue_fire, retire, retire_load;
    entry_t            head_ent, issue_ent;

    // Word-select bits of request addresses are not needed at line granularity.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ld_miss_addr, wb_addr};

    assign head_ent  = q[head_ptr];
    assign issue_ent = q[issue_ptr];

    // ------------------------------------------------------------------
    // Issue: the oldest not-yet-issued entry sits at issue_ptr. Testing the
    // entry itself (rather than issue_ptr != tail_ptr) keeps a completely
    // full, unissued queue from looking empty.
    // ------------------------------------------------------------------
    assign issue_req  = !reset && issue_ent.valid && !issue_ent.issued;
    assign issue_fire = issue_req && (mem_response != '0);

    assign mem_command = issue_req ? issue_ent.cmd : BUS_NONE;
    assign mem_addr    = issue_req ? {issue_ent.line, 3'b000} : '0;
    assign mem_data    = (issue_req && issue_ent.cmd == BUS_STORE) ? issue_ent.data : '0;

    // ------------------------------------------------------------------
    // Retire: only the head may complete; tag 0 never matches.
    // ------------------------------------------------------------------
    assign retire = !reset && head_ent.valid && head_ent.issued &&
                    (mem_tag != '0) && (mem_tag == head_ent.mtag);
    assign retire_load = retire && (head_ent.cmd == BUS_LOAD);

    assign refill_en   = retire_load;
    assign refill_addr = retire_load ? {head_ent.line, 3'b000} : '0;
    assign refill_data = retire_load ? mem_rdata : '0;
    assign bcast_valid = retire_load;
    assign bcast_addr  = retire_load ? {head_ent.line, 3'b000} : '0;
    assign bcast_data  = retire_load ? mem_rdata : '0;

    // ------------------------------------------------------------------
    // Allocation / merge, ports in priority order (loads, then writebacks).
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]             free_slots, n_new;
    logic                         refused, yng_hit, yng_load;
    logic [PTR_W-1:0]             scan_idx;
    logic [LINE_W-1:0]            req_line;
    entry_t [NPORTS-1:0]          new_ent;
    logic [NPORTS-1:0][PTR_W-1:0] new_slot;

    always_comb begin
        ld_accept  = '0;
        ld_stall   = '0;
        wb_stall   = '0;
        new_ent    = '0;
        new_slot   = '0;
        free_slots = CNT_W'(DEPTH) - count;   // a same-cycle retire is not credited
        n_new      = '0;
        refused    = 1'b0;
        yng_hit    = 1'b0;
        yng_load   = 1'b0;
        scan_idx   = '0;
        req_line   = '0;

        for (int p = 0; p < LD_PORTS; p++) begin
            if (ld_miss_valid[p] && !reset) begin
                req_line = ld_miss_addr[p][XLEN-1:3];
                yng_hit  = 1'b0;
                yng_load = 1'b0;
                // Oldest to youngest, so the last hit is the youngest entry.
                for (int k = 0; k < DEPTH; k++) begin
                    scan_idx = head_ptr + PTR_W'(k);
                    if (CNT_W'(k) < count && q[scan_idx].valid &&
                        q[scan_idx].line == req_line) begin
                        yng_hit  = 1'b1;
                        yng_load = (q[scan_idx].cmd == BUS_LOAD) && !(retire && k == 0);
                    end
                end
                // Earlier same-cycle allocations are younger than anything queued.
                for (int j = 0; j < p; j++) begin
                    if (new_ent[j].valid && new_ent[j].line == req_line) begin
                        yng_hit  = 1'b1;
                        yng_load = (new_ent[j].cmd == BUS_LOAD);
                    end
                end

                if (refused) begin
                    ld_stall[p] = 1'b1;
                end else if (yng_hit && yng_load) begin
                    ld_accept[p] = 1'b1;
                end else if (n_new < free_slots) begin
                    ld_accept[p]      = 1'b1;
                    new_ent[p].valid  = 1'b1;
                    new_ent[p].cmd    = BUS_LOAD;
                    new_ent[p].line   = req_line;
                    new_slot[p]       = tail_ptr + n_new[PTR_W-1:0];
                    n_new             = n_new + CNT_W'(1);
                end else begin
                    ld_stall[p] = 1'b1;
                    refused     = 1'b1;
                end
            end
        end

        for (int s = 0; s < ST_PORTS; s++) begin
            if (wb_valid[s] && !reset) begin
                if (refused || n_new >= free_slots) begin
                    wb_stall[s] = 1'b1;
                    refused     = 1'b1;
                end else begin
                    new_ent[LD_PORTS+s].valid = 1'b1;
                    new_ent[LD_PORTS+s].cmd   = BUS_STORE;
                    new_ent[LD_PORTS+s].line  = wb_addr[s][XLEN-1:3];
                    new_ent[LD_PORTS+s].data  = wb_data[s];
                    new_slot[LD_PORTS+s]      = tail_ptr + n_new[PTR_W-1:0];
                    n_new                     = n_new + CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State. Issue, retire and allocation always touch distinct slots:
    // allocations land in free slots, retire needs an already-issued head.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            head_ptr  <= '0;
            issue_ptr <= '0;
            tail_ptr  <= '0;
            count     <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else begin
            if (issue_fire) begin
                q[issue_ptr].issued <= 1'b1;
                q[issue_ptr].mtag   <= mem_response;
                issue_ptr           <= issue_ptr + PTR_W'(1);
            end
            if (retire) begin
                q[head_ptr].valid  <= 1'b0;
                q[head_ptr].issued <= 1'b0;
                head_ptr           <= head_ptr + PTR_W'(1);
            end
            for (int p = 0; p < NPORTS; p++) begin
                if (new_ent[p].valid) q[new_slot[p]] <= new_ent[p];
            end
            tail_ptr <= tail_ptr + n_new[PTR_W-1:0];
            count    <= count + n_new - CNT_W'(retire);
        end
    end

endmodule

// File: tb/tb_dcache_mshr_queue.sv
// Randomized + directed bench for dcache_mshr_queue against a queue-based
// reference model of the miss queue.
module tb_dcache_mshr_queue;

    localparam int XLEN = 32, LD_PORTS = 2, ST_PORTS = 3, DEPTH = 8, MTAG_W = 4;
    localparam logic [1:0] BUS_NONE = 2'd0, BUS_LOAD = 2'd1, BUS_STORE = 2'd2;

    logic                           clock = 1'b0;
    logic                           reset;
    logic [LD_PORTS-1:0]            ld_miss_valid;
    logic [LD_PORTS-1:0][XLEN-1:0]  ld_miss_addr;
    logic [LD_PORTS-1:0]            ld_accept, ld_stall;
    logic [ST_PORTS-1:0]            wb_valid;
    logic [ST_PORTS-1:0][XLEN-1:0]  wb_addr;
    logic [ST_PORTS-1:0][63:0]      wb_data;
    logic [ST_PORTS-1:0]            wb_stall;
    logic [1:0]                     mem_command;
    logic [XLEN-1:0]                mem_addr;
    logic [63:0]                    mem_data;
    logic [MTAG_W-1:0]              mem_response, mem_tag;
    logic [63:0]                    mem_rdata;
    logic                           refill_en, bcast_valid;
    logic [XLEN-1:0]                refill_addr, bcast_addr;
    logic [63:0]                    refill_data, bcast_data;

    always #5 clock = ~clock;

    dcache_mshr_queue #(.XLEN(XLEN), .LD_PORTS(LD_PORTS), .ST_PORTS(ST_PORTS),
                        .DEPTH(DEPTH), .MTAG_W(MTAG_W)) dut (
        .clock(clock), .reset(reset),
        .ld_miss_valid(ld_miss_valid), .ld_miss_addr(ld_miss_addr),
        .ld_accept(ld_accept), .ld_stall(ld_stall),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
        .mem_command(mem_command), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_response(mem_response), .mem_tag(mem_tag), .mem_rdata(mem_rdata),
        .refill_en(refill_en), .refill_addr(refill_addr), .refill_data(refill_data),
        .bcast_valid(bcast_valid), .bcast_addr(bcast_addr), .bcast_data(bcast_data)
    );

    // Reference model: pending requests, oldest first.
    typedef struct {
        logic [1:0]       cmd;
        logic [XLEN-4:0]  line;
        logic [63:0]      data;
        bit               issued;
        logic [MTAG_W-1:0] mtag;
    } ment_t;

    ment_t      mq[$];
    ment_t      m_new[$];
    logic [1:0] obs_issues[$];
    int         m_ui;
    bit         m_issue, m_retire;
    logic [MTAG_W-1:0] m_resp;
    int         n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic idle_in();
        ld_miss_valid = '0; ld_miss_addr = '0;
        wb_valid = '0; wb_addr = '0; wb_data = '0;
        mem_response = '0; mem_tag = '0; mem_rdata = '0;
    endtask

    function automatic bit has_unissued();
        foreach (mq[i]) if (!mq[i].issued) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [MTAG_W-1:0] fresh_tag();
        int s = $urandom_range(0, 14);
        for (int k = 0; k < 15; k++) begin
            logic [MTAG_W-1:0] t = MTAG_W'(((s + k) % 15) + 1);
            bit used = 1'b0;
            foreach (mq[i]) if (mq[i].issued && mq[i].mtag == t) used = 1'b1;
            if (!used) return t;
        end
        return MTAG_W'(1);
    endfunction

    // Settle, predict from the model, compare every output.
    task automatic settle_check();
        int ui, free;
        bit refused, found, is_ld;
        logic [XLEN-4:0] ln;
        logic [1:0] e_cmd;
        logic [LD_PORTS-1:0] e_acc, e_lst;
        logic [ST_PORTS-1:0] e_wst;
        ment_t ne;
        #1;
        if (reset) begin
            chk("rst_cmd", mem_command, BUS_NONE);
            chk("rst_refill", {refill_en, bcast_valid}, 0);
            chk("rst_hs", {ld_accept, ld_stall, wb_stall}, 0);
            return;
        end
        ui = -1;
        foreach (mq[i]) if (!mq[i].issued && ui < 0) ui = i;
        e_cmd    = (ui >= 0) ? mq[ui].cmd : BUS_NONE;
        m_ui     = ui;
        m_resp   = mem_response;
        m_issue  = (ui >= 0) && (mem_response != 0);
        m_retire = (mq.size() > 0) && mq[0].issued && (mem_tag != 0) && (mem_tag == mq[0].mtag);

        chk("mem_command", mem_command, e_cmd);
        chk("mem_addr", mem_addr, (ui >= 0) ? {mq[ui].line, 3'b000} : 0);
        chk("mem_data", mem_data, (ui >= 0 && mq[ui].cmd == BUS_STORE) ? mq[ui].data : 0);
        if (m_retire && mq[0].cmd == BUS_LOAD) begin
            chk("refill_en", refill_en, 1);
            chk("refill_addr", refill_addr, {mq[0].line, 3'b000});
            chk("refill_data", refill_data, mem_rdata);
            chk("bcast_valid", bcast_valid, 1);
            chk("bcast_addr", bcast_addr, {mq[0].line, 3'b000});
            chk("bcast_data", bcast_data, mem_rdata);
        end else begin
            chk("no_refill", {refill_en, bcast_valid}, 0);
        end

        m_new.delete();
        free = DEPTH - mq.size();
        refused = 1'b0;
        e_acc = '0; e_lst = '0; e_wst = '0;
        for (int p = 0; p < LD_PORTS; p++) begin
            if (ld_miss_valid[p]) begin
                ln = ld_miss_addr[p][XLEN-1:3];
                found = 1'b0; is_ld = 1'b0;
                for (int i = m_new.size() - 1; i >= 0 && !found; i--)
                    if (m_new[i].line == ln) begin found = 1'b1; is_ld = (m_new[i].cmd == BUS_LOAD); end
                for (int i = mq.size() - 1; i >= 0 && !found; i--)
                    if (mq[i].line == ln) begin
                        found = 1'b1;
                        is_ld = (mq[i].cmd == BUS_LOAD) && !(i == 0 && m_retire);
                    end
                if (refused) e_lst[p] = 1'b1;
                else if (found && is_ld) e_acc[p] = 1'b1;
                else if (m_new.size() < free) begin
                    e_acc[p] = 1'b1;
                    ne = '{cmd: BUS_LOAD, line: ln, data: 64'd0, issued: 1'b0, mtag: '0};
                    m_new.push_back(ne);
                end else begin
                    e_lst[p] = 1'b1; refused = 1'b1;
                end
            end
        end
        for (int s = 0; s < ST_PORTS; s++) begin
            if (wb_valid[s]) begin
                if (refused || m_new.size() >= free) begin
                    e_wst[s] = 1'b1; refused = 1'b1;
                end else begin
                    ne = '{cmd: BUS_STORE, line: wb_addr[s][XLEN-1:3], data: wb_data[s], issued: 1'b0, mtag: '0};
                    m_new.push_back(ne);
                end
            end
        end
        chk("ld_accept", ld_accept, e_acc);
        chk("ld_stall", ld_stall, e_lst);
        chk("wb_stall", wb_stall, e_wst);
        chk("count", dut.count, mq.size());
        if (mem_command != BUS_NONE && mem_response != 0) obs_issues.push_back(mem_command);
    endtask

    // Clock edge: commit the model, return at the next falling edge.
    task automatic advance();
        @(posedge clock);
        if (reset) mq.delete();
        else begin
            if (m_issue) begin mq[m_ui].issued = 1'b1; mq[m_ui].mtag = m_resp; end
            if (m_retire) void'(mq.pop_front());
            foreach (m_new[i]) mq.push_back(m_new[i]);
        end
        @(negedge clock);
    endtask

    task automatic step();
        settle_check();
        advance();
    endtask

    task automatic ld0(input logic [XLEN-1:0] a);
        idle_in(); ld_miss_valid = 2'b01; ld_miss_addr[0] = a; step();
    endtask

    // Acts as memory until the model queue is empty (bounded).
    task automatic drain();
        int budget = 200;
        while (mq.size() > 0 && budget > 0) begin
            idle_in();
            if (has_unissued()) mem_response = fresh_tag();
            if (mq[0].issued) begin mem_tag = mq[0].mtag; mem_rdata = {$urandom, $urandom}; end
            step();
            budget--;
        end
        if (mq.size() != 0) chk("drain_timeout", mq.size(), 0);
        chk("drain_count", dut.count, 0);
    endtask

    initial begin
        idle_in();
        reset = 1'b1;
        @(negedge clock);
        step(); step();
        reset = 1'b0;

        // Idle after reset
        repeat (10) step();
        chk("idle_cmd", mem_command, BUS_NONE);

        // Single miss
        obs_issues.delete();
        ld0(32'h1004);
        idle_in(); mem_response = 4'd3; settle_check();
        chk("miss_cmd", mem_command, BUS_LOAD);
        chk("miss_addr", mem_addr, 32'h1000);
        advance();
        idle_in(); step();
        idle_in(); mem_tag = 4'd3; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD; settle_check();
        chk("miss_refill_en", refill_en, 1);
        chk("miss_bcast_addr", bcast_addr, 32'h1000);
        chk("miss_refill_data", refill_data, 64'hAAAA_BBBB_CCCC_DDDD);
        advance();
        chk("miss_n_issue", obs_issues.size(), 1);

        // Merge: same-cycle and against queued load
        obs_issues.delete();
        idle_in(); ld_miss_valid = 2'b11; ld_miss_addr[0] = 32'h2000; ld_miss_addr[1] = 32'h2004;
        settle_check(); chk("merge_acc_a", ld_accept, 2'b11); advance();
        ld_miss_valid = 2'b01; ld_miss_addr[1] = '0;
        settle_check(); chk("merge_acc_b", ld_accept, 2'b01); advance();
        chk("merge_count", dut.count, 1);
        drain();
        chk("merge_n_issue", obs_issues.size(), 1);

        // Store fence
        obs_issues.delete();
        ld0(32'h3000);
        idle_in(); wb_valid = 3'b001; wb_addr[0] = 32'h3000; wb_data[0] = 64'h1111_2222_3333_4444; step();
        ld0(32'h3004);
        chk("fence_count", dut.count, 3);
        drain();
        chk("fence_n_issue", obs_issues.size(), 3);
        chk("fence_order", {obs_issues[0], obs_issues[1], obs_issues[2]}, {BUS_LOAD, BUS_STORE, BUS_LOAD});

        // Full
        for (int i = 0; i < 7; i++) ld0(XLEN'(32'h8000 + i * 8));
        idle_in(); ld_miss_valid = 2'b11; ld_miss_addr[0] = 32'h9000; ld_miss_addr[1] = 32'h9008;
        wb_valid = 3'b001; wb_addr[0] = 32'hA000; wb_data[0] = 64'h55;
        settle_check();
        chk("full_acc", ld_accept, 2'b01);
        chk("full_ld_stall", ld_stall, 2'b10);
        chk("full_wb_stall", wb_stall, 3'b001);
        advance();
        chk("full_count", dut.count, 8);
        idle_in(); ld_miss_valid = 2'b11; ld_miss_addr[0] = 32'h8004; ld_miss_addr[1] = 32'h9010;
        settle_check();
        chk("full_merge_acc", ld_accept, 2'b01);
        chk("full_merge_stall", ld_stall, 2'b10);
        advance();
        drain();

        // Pointer wrap
        for (int i = 0; i < 20; i++) begin
            ld0(XLEN'(32'h5000 + i * 8));
            drain();
        end

        // Reset with outstanding issued requests
        for (int i = 0; i < 3; i++) ld0(XLEN'(32'h6000 + i * 8));
        for (int i = 0; i < 3; i++) begin idle_in(); mem_response = MTAG_W'(i + 1); step(); end
        chk("pre_rst_count", dut.count, 3);
        idle_in(); reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle_in(); mem_tag = MTAG_W'(i + 1); mem_rdata = 64'hDEAD;
            settle_check(); chk("rst_norefill", refill_en, 0); advance();
        end
        chk("rst_count", dut.count, 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            idle_in();
            for (int p = 0; p < LD_PORTS; p++) begin
                ld_miss_valid[p] = ($urandom_range(0, 99) < 40);
                ld_miss_addr[p]  = XLEN'(32'h4000 + $urandom_range(0, 5) * 8 + $urandom_range(0, 1) * 4);
            end
            for (int s = 0; s < ST_PORTS; s++) begin
                wb_valid[s] = ($urandom_range(0, 99) < 10);
                wb_addr[s]  = XLEN'(32'h4000 + $urandom_range(0, 5) * 8 + $urandom_range(0, 7));
                wb_data[s]  = {$urandom, $urandom};
            end
            r = $urandom_range(0, 99);
            if (has_unissued()) begin
                if (r < 50) mem_response = fresh_tag();
            end else if (r >= 80) mem_response = MTAG_W'($urandom_range(1, 15));
            r = $urandom_range(0, 99);
            if (mq.size() > 0 && mq[0].issued && r < 35) mem_tag = mq[0].mtag;
            else if (r >= 85) mem_tag = MTAG_W'($urandom_range(1, 15));
            mem_rdata = {$urandom, $urandom};
            reset = ($urandom_range(0, 499) == 0);
            step();
            reset = 1'b0;
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
